cfg_scan_chain: RTL

Parametrised configuration scan chain with a W-lane serial shift path, a length-checked shadow register and parallel capture for readback. Configuration words are shifted in over multiple cycles and committed to the shadow register atomically, only when exactly N bits were shifted. It drives static configuration buses, such as PLL divider and charge-pump trim, from a narrow serial interface.

---
 rtl/cfg_scan_chain.sv | 93 +++++++++
 1 files changed

// File: rtl/cfg_scan_chain.sv
// cfg_scan_chain: W-lane configuration scan chain with a length-checked shadow register and capture readback.
// Optional feature macro CFG_PARITY_EN: an update commits only when even parity over sr plus par_in holds.
module cfg_scan_chain #(
   parameter int N = 96,
   parameter int W = 4,
   parameter logic [N-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         shift_en,
   input  logic [W-1:0] s_in,
   output logic [W-1:0] s_out,
   input  logic         update,
   input  logic         capture,
   input  logic [N-1:0] cap_data,
   output logic [N-1:0] cfg_out,
   output logic         full,
   output logic         len_err,
   input  logic         err_clr,
   input  logic         par_in
);
   localparam int WORDS = N / W;
   localparam int CW = $clog2(WORDS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
   localparam logic [CW-1:0] CNT_OVER = CW'(WORDS + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;
   state_t state_q, state_d;
   logic [N-1:0] sr_q, sr_d, sr_shift, cfg_q, cfg_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic err_q, err_d, par_ok;

   generate
      if (N == W) begin : g_one
         assign sr_shift = s_in;
      end else begin : g_multi
         assign sr_shift = {s_in, sr_q[N-1:W]};
      end
   endgenerate

`ifdef CFG_PARITY_EN
   assign par_ok = (^sr_q) == par_in;
`else
   logic unused_par;
   assign unused_par = par_in;
   assign par_ok = 1'b1;
`endif

   // The counter saturates one past full so any over-length load stays detectable.
   assign cnt_inc = (cnt_q == CNT_OVER) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      sr_d = sr_q;
      cnt_d = cnt_q;
      cfg_d = cfg_q;
      err_d = err_clr ? 1'b0 : err_q;
      if (capture) begin
         sr_d = cap_data;
         cnt_d = '0;
         state_d = IDLE;
      end else if (update) begin
         if (state_q == FULL && par_ok) cfg_d = sr_q;
         else err_d = 1'b1;
         cnt_d = '0;
         state_d = IDLE;
      end else if (shift_en) begin
         sr_d = sr_shift;
         cnt_d = cnt_inc;
         state_d = (cnt_inc == CNT_FULL) ? FULL : (cnt_inc == CNT_OVER) ? OVER : SHIFT;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sr_q <= '0;
         cnt_q <= '0;
         cfg_q <= INIT;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q <= sr_d;
         cnt_q <= cnt_d;
         cfg_q <= cfg_d;
         err_q <= err_d;
      end
   end

   assign s_out = sr_q[W-1:0];
   assign cfg_out = cfg_q;
   assign full = (state_q == FULL);
   assign len_err = err_q;
endmodule
